ddr_traffic_gen: RTL

- Write/read-back traffic generator and checker driving the DDR3 controller user (app) interface.
- Sits directly upstream of the DDR3 controller, in the controller's user clock domain.
- Writes a deterministic pattern over an address window, reads it back and compares every beat.
- Exposes wdone/rdone/pass/error status for LEDs and for the on-chip logic analyzer probes.

---
 rtl/ddr_traffic_pkg.sv | 13 +
 rtl/ddr_pattern_gen.sv | 31 +++
 rtl/ddr_traffic_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ddr_traffic_pkg.sv
// ddr_traffic_pkg: FSM states, command codes and pattern helpers shared by the traffic generator.
package ddr_traffic_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, DONE} state_e;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic logic [31:0] pat_lane(input logic [31:0] word, input int k);
    return word ^ 32'(k);
  endfunction
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? (s >> 1) ^ LFSR_POLY : s >> 1;
  endfunction
endpackage

// File: rtl/ddr_pattern_gen.sv
// ddr_pattern_gen: per-beat data pattern source; index-XOR pattern by default,
// Galois LFSR lanes when DDR_TRAFFIC_PRBS_EN is defined.
module ddr_pattern_gen
  import ddr_traffic_pkg::*;
#(
  parameter int          DATA_WIDTH = 128,
  parameter logic [31:0] SEED       = 32'h1234_5678
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_i,
  input  logic                  step_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [31:0] state_q, state_d, word;
`ifdef DDR_TRAFFIC_PRBS_EN
  localparam logic [31:0] INIT = SEED;
  assign state_d = init_i ? INIT : step_i ? lfsr_step(state_q) : state_q;
  assign word = state_q;
`else
  localparam logic [31:0] INIT = '0;
  assign state_d = init_i ? INIT : step_i ? state_q + 32'd1 : state_q;
  assign word = SEED ^ state_q;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= INIT;
    else state_q <= state_d;
  for (genvar k = 0; k < DATA_WIDTH / 32; k++) begin : g_lane
    assign data_o[k*32 +: 32] = pat_lane(word, k);
  end
endmodule

// File: rtl/ddr_traffic_gen.sv
// ddr_traffic_gen: writes a pattern over an address window through the DDR3 app
// interface, reads it back and checks every beat in order.
module ddr_traffic_gen
  import ddr_traffic_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 28,
  parameter int                    DATA_WIDTH     = 128,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
  parameter int                    NUM_WORDS      = 1024,
  parameter int                    ADDR_STEP      = 8,
  parameter logic [31:0]           SEED           = 32'h1234_5678,
  parameter int                    TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    init_calib_complete,
  input  logic                    app_rdy,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_burst,
  input  logic                    app_wdf_rdy,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    busy,
  output logic                    wdone,
  output logic                    rdone,
  output logic                    pass,
  output logic                    error,
  output logic [15:0]             err_cnt,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);
  localparam logic [31:0] LAST = 32'(NUM_WORDS - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);
  state_e st_q, st_d;
  logic [31:0] idx_q, idx_d, ret_q, ret_d, tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ret_addr_q, ret_addr_d, first_err_addr_q, first_err_addr_d;
  logic cmd_done_q, cmd_done_d, dat_done_q, dat_done_d;
  logic wdone_q, wdone_d, rdone_q, rdone_d, pass_q, pass_d, error_q, error_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic wgen_init, wgen_step, rgen_init;
  logic [DATA_WIDTH-1:0] rpat;
  logic cmd_ok, dat_ok, checking, ret_ok, miss;
  ddr_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .SEED(SEED)) u_wgen (
    .clk(clk), .rst(rst), .init_i(wgen_init), .step_i(wgen_step), .data_o(app_wdf_data)
  );
  ddr_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .SEED(SEED)) u_rgen (
    .clk(clk), .rst(rst), .init_i(rgen_init), .step_i(ret_ok), .data_o(rpat)
  );
  assign busy = st_q != IDLE && st_q != DONE;
  assign app_en = (st_q == WRITE && !cmd_done_q) || st_q == READ;
  assign app_cmd = st_q == READ ? CMD_RD : CMD_WR;
  assign app_addr = addr_q;
  assign app_burst = 1'b0;
  assign app_wdf_wren = st_q == WRITE && !dat_done_q;
  assign app_wdf_end = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign wdone = wdone_q;
  assign rdone = rdone_q;
  assign pass = pass_q;
  assign error = error_q;
  assign err_cnt = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign cmd_ok = app_en && app_rdy;
  assign dat_ok = app_wdf_wren && app_wdf_rdy;
  assign checking = st_q == READ || st_q == RWAIT;
  assign ret_ok = checking && app_rd_data_valid;
  assign miss = ret_ok && app_rd_data != rpat;
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    addr_d = addr_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    wdone_d = wdone_q;
    rdone_d = rdone_q;
    pass_d = pass_q;
    wgen_init = 1'b0;
    wgen_step = 1'b0;
    rgen_init = 1'b0;
    ret_d = ret_ok ? ret_q + 32'd1 : ret_q;
    ret_addr_d = ret_ok ? ret_addr_q + STEP : ret_addr_q;
    tmo_d = checking ? (ret_ok ? '0 : tmo_q + 32'd1) : '0;
    err_cnt_d = miss && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;
    first_err_addr_d = miss && err_cnt_q == '0 ? ret_addr_q : first_err_addr_q;
    // Data outside the read phases is spurious: flagged, but not counted as a miss.
    error_d = error_q | miss | (app_rd_data_valid && !checking);
    if (busy && !init_calib_complete) begin
      error_d = 1'b1;
      st_d = DONE;
    end else begin
      case (st_q)
        IDLE: if (start && init_calib_complete) begin
          st_d = WRITE;
          idx_d = '0;
          addr_d = START_ADDR;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          wdone_d = 1'b0;
          rdone_d = 1'b0;
          pass_d = 1'b0;
          error_d = 1'b0;
          err_cnt_d = '0;
          first_err_addr_d = '0;
          wgen_init = 1'b1;
        end
        WRITE: if ((cmd_done_q || cmd_ok) && (dat_done_q || dat_ok)) begin
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          wgen_step = 1'b1;
          idx_d = idx_q + 32'd1;
          addr_d = addr_q + STEP;
          if (idx_q == LAST) begin
            wdone_d = 1'b1;
            st_d = READ;
            idx_d = '0;
            addr_d = START_ADDR;
            ret_d = '0;
            ret_addr_d = START_ADDR;
            rgen_init = 1'b1;
          end
        end else begin
          cmd_done_d = cmd_done_q | cmd_ok;
          dat_done_d = dat_done_q | dat_ok;
        end
        READ: if (app_rdy) begin
          idx_d = idx_q + 32'd1;
          addr_d = addr_q + STEP;
          st_d = idx_q == LAST ? RWAIT : READ;
        end
        RWAIT: if (ret_q == 32'(NUM_WORDS)) begin
          rdone_d = 1'b1;
          pass_d = !error_q;
          st_d = DONE;
        end
        default: if (!start) st_d = IDLE;
      endcase
      if (checking && !ret_ok && tmo_q == TMO_LAST) begin
        error_d = 1'b1;
        rdone_d = 1'b1;
        pass_d = 1'b0;
        st_d = DONE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      idx_q <= '0;
      ret_q <= '0;
      tmo_q <= '0;
      addr_q <= START_ADDR;
      ret_addr_q <= START_ADDR;
      first_err_addr_q <= '0;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
      wdone_q <= 1'b0;
      rdone_q <= 1'b0;
      pass_q <= 1'b0;
      error_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      ret_q <= ret_d;
      tmo_q <= tmo_d;
      addr_q <= addr_d;
      ret_addr_q <= ret_addr_d;
      first_err_addr_q <= first_err_addr_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
      wdone_q <= wdone_d;
      rdone_q <= rdone_d;
      pass_q <= pass_d;
      error_q <= error_d;
      err_cnt_q <= err_cnt_d;
    end
endmodule
